// File: rtl/vgabounce.sv
// Animated pixel source: a solid square bouncing diagonally on a solid background.
// Optional 1-pixel white frame around the active area when VGABOUNCE_BORDER_EN is defined.
module vgabounce #(
    parameter int                          BITS_PER_COLOR = 8,
    parameter int                          HW             = 16,
    parameter int                          BOX_SIZE       = 32,
    parameter int                          STEP           = 2,
    parameter logic [3*BITS_PER_COLOR-1:0] FG_COLOR       = 24'hFFFF00,
    parameter logic [3*BITS_PER_COLOR-1:0] BG_COLOR       = 24'h000080
) (
    input  logic                          i_pixclk,
    input  logic                          i_reset,
    input  logic [HW-1:0]                 i_width,
    input  logic [HW-1:0]                 i_height,
    input  logic                          i_rd,
    input  logic                          i_newline,
    input  logic                          i_newframe,
    output logic [3*BITS_PER_COLOR-1:0]   o_pixel
);

    typedef struct packed {
        logic [HW-1:0] pos;
        logic          dir;   // 1 = moving towards larger coordinates
    } axis_t;

    localparam logic [HW-1:0] ONE    = HW'(1);
    localparam logic [HW-1:0] STEP_H = HW'(STEP);
    localparam logic [HW:0]   STEP_W = (HW+1)'(STEP);
    localparam logic [HW:0]   BOX_W  = (HW+1)'(BOX_SIZE);

    localparam axis_t AXIS_RESET = '{pos: '0, dir: 1'b1};

    logic [HW-1:0] x;
    logic [HW-1:0] y;
    axis_t         box_x;
    axis_t         box_y;

    // One frame of motion along one axis; the edge test is widened by a bit so it cannot wrap.
    function automatic axis_t bounce(input axis_t a, input logic [HW-1:0] limit);
        axis_t r;
        r = a;
        if (a.dir) begin
            if ({1'b0, a.pos} + BOX_W + STEP_W > {1'b0, limit}) begin
                r.dir = 1'b0;
                r.pos = a.pos - STEP_H;
            end else begin
                r.pos = a.pos + STEP_H;
            end
        end else begin
            if ({1'b0, a.pos} < STEP_W) begin
                r.dir = 1'b1;
                r.pos = a.pos + STEP_H;
            end else begin
                r.pos = a.pos - STEP_H;
            end
        end
        return r;
    endfunction

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            x     <= '0;
            y     <= '0;
            box_x <= AXIS_RESET;
            box_y <= AXIS_RESET;
        end else if (i_newframe) begin
            x     <= '0;
            y     <= '0;
            box_x <= bounce(box_x, i_width);
            box_y <= bounce(box_y, i_height);
        end else if (i_newline) begin
            x <= '0;
            if (y < i_height) begin
                y <= y + ONE;
            end
        end else if (i_rd) begin
            if (x < i_width) begin
                x <= x + ONE;
            end
        end
    end

    logic active;
    logic in_box;

    assign active = (x < i_width) && (y < i_height);
    assign in_box = ({1'b0, x} >= {1'b0, box_x.pos}) && ({1'b0, x} < {1'b0, box_x.pos} + BOX_W)
                 && ({1'b0, y} >= {1'b0, box_y.pos}) && ({1'b0, y} < {1'b0, box_y.pos} + BOX_W);

`ifdef VGABOUNCE_BORDER_EN
    logic on_border;
    assign on_border = (x == '0) || (x == i_width - ONE) || (y == '0) || (y == i_height - ONE);
`endif

    // NOTE: o_pixel gets a default before any branch so no latch is inferred.
    always_comb begin
        o_pixel = '0;
        if (active) begin
            o_pixel = in_box ? FG_COLOR : BG_COLOR;
`ifdef VGABOUNCE_BORDER_EN
            if (on_border) begin
                o_pixel = '1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_vgabounce.sv
// Self-checking bench for vgabounce: an integer position/direction model checked every cycle,
// plus directed probes with hand-computed colours for the first line, bounces, priority and reset.
module tb_vgabounce;

    localparam logic [23:0] FG    = 24'hFFFF00;
    localparam logic [23:0] BG    = 24'h000080;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;
    localparam int W = 640;
    localparam int H = 480;
    localparam int BOX = 32;
    localparam int STP = 2;

    logic        i_pixclk = 1'b0;
    logic        i_reset;
    logic [15:0] i_width;
    logic [15:0] i_height;
    logic        i_rd;
    logic        i_newline;
    logic        i_newframe;
    logic [23:0] o_pixel;

    int n_tests = 0;
    int n_fail  = 0;

    vgabounce dut (
        .i_pixclk   (i_pixclk),
        .i_reset    (i_reset),
        .i_width    (i_width),
        .i_height   (i_height),
        .i_rd       (i_rd),
        .i_newline  (i_newline),
        .i_newframe (i_newframe),
        .o_pixel    (o_pixel)
    );

    always #5 i_pixclk = ~i_pixclk;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain integers, direction as +1/-1.
    int  mx, my, mbx, mby, mdx, mdy;
    bit  model_ok = 1'b0;

    task automatic move(inout int pos, inout int dir, input int limit);
        int nxt;
        nxt = pos + dir * STP;
        if (nxt < 0 || nxt + BOX > limit) begin
            dir = -dir;
            nxt = pos + dir * STP;
        end
        pos = nxt;
    endtask

    function automatic logic [23:0] model_pix();
        if (mx >= W || my >= H) return BLACK;
`ifdef VGABOUNCE_BORDER_EN
        if (mx == 0 || mx == W - 1 || my == 0 || my == H - 1) return WHITE;
`endif
        if (mx >= mbx && mx < mbx + BOX && my >= mby && my < mby + BOX) return FG;
        return BG;
    endfunction

    always @(posedge i_pixclk) begin
        if (i_reset) begin
            mx = 0; my = 0; mbx = 0; mby = 0; mdx = 1; mdy = 1;
            model_ok = 1'b1;
        end else if (i_newframe) begin
            mx = 0; my = 0;
            move(mbx, mdx, W);
            move(mby, mdy, H);
        end else if (i_newline) begin
            mx = 0;
            if (my < H) my = my + 1;
        end else if (i_rd) begin
            if (mx < W) mx = mx + 1;
        end
    end

    always @(negedge i_pixclk) begin
        if (model_ok) check("pixel_vs_model", o_pixel, model_pix());
    end

    // Literal expectation that differs between the plain and bordered builds.
    function automatic logic [23:0] lit(input logic [23:0] plain, input logic [23:0] border);
`ifdef VGABOUNCE_BORDER_EN
        return border;
`else
        return plain;
`endif
    endfunction

    task automatic step(input logic rd, input logic nl, input logic nf);
        i_rd = rd; i_newline = nl; i_newframe = nf;
        @(negedge i_pixclk);
        i_rd = 1'b0; i_newline = 1'b0; i_newframe = 1'b0;
    endtask

    task automatic rd_n(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic nl_n(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic nf_n(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int k;
        int sbx, sby;
        i_reset = 1'b1; i_rd = 1'b0; i_newline = 1'b0; i_newframe = 1'b0;
        i_width = 16'(W); i_height = 16'(H);
        repeat (3) @(negedge i_pixclk);
        i_reset = 1'b0;

        // First line
        check("reset_pix", o_pixel, lit(FG, WHITE));
        rd_n(5);
        check("x5_pix", o_pixel, lit(FG, WHITE));
        rd_n(27);
        check("x32_pix", o_pixel, lit(BG, WHITE));
        rd_n(608);
        check("x640_pix", o_pixel, BLACK);
        rd_n(3);
        check("x_saturate_pix", o_pixel, BLACK);
        check_int("x_saturate_model", mx, 640);

        // Mid-operation reset at x=100, y=200, bx=50
        nf_n(25);
        check_int("bx_after25", mbx, 50);
        nl_n(200);
        rd_n(100);
        check_int("x_before_reset", mx, 100);
        check_int("y_before_reset", my, 200);
        i_reset = 1'b1;
        @(negedge i_pixclk);
        i_reset = 1'b0;
        check("midreset_pix", o_pixel, lit(FG, WHITE));
        check_int("midreset_bx", mbx, 0);
        check_int("midreset_by", mby, 0);
        check_int("midreset_dx", mdx, 1);
        check_int("midreset_dy", mdy, 1);

        // Bottom bounce: by peaks at 448 on frame 224
        nf_n(224);
        check_int("by_f224", mby, 448);
        check_int("bx_f224", mbx, 448);
        nl_n(448);
        rd_n(448);
        check("box_corner_f224", o_pixel, FG);
        nf_n(1);
        check_int("by_f225", mby, 446);
        check_int("dy_f225", mdy, -1);

        // Right bounce: bx peaks at 608 on frame 304
        nf_n(79);
        check_int("bx_f304", mbx, 608);
        check_int("dx_f304", mdx, 1);
        check_int("by_f304", mby, 288);
        nl_n(288);
        rd_n(607);
        check("left_of_box_f304", o_pixel, BG);
        rd_n(1);
        check("box_left_edge_f304", o_pixel, FG);
        rd_n(31);
        check("x639_f304", o_pixel, lit(FG, WHITE));
        nf_n(1);
        check_int("bx_f305", mbx, 606);
        check_int("dx_f305", mdx, -1);
        step(1'b0, 1'b1, 1'b0);
        rd_n(1);
        check("line1_x1_bg", o_pixel, BG);
        nl_n(490);
        check("y_saturate_pix", o_pixel, BLACK);
        check_int("y_saturate_model", my, 480);

        // Left bounce
        k = 0;
        while (mbx != 2 && k < 1000) begin
            nf_n(1);
            k++;
        end
        check_int("frames_to_bx2", k, 302);
        nf_n(1);
        check_int("bx_left_0", mbx, 0);
        check_int("dx_left_0", mdx, -1);
        nf_n(1);
        check_int("bx_left_2", mbx, 2);
        check_int("dx_left_2", mdx, 1);

        // Priority: newframe beats newline and rd in the same cycle
        nf_n(1);
        nl_n(5);
        rd_n(10);
        check_int("prio_x_before", mx, 10);
        check_int("prio_y_before", my, 5);
        sbx = mbx;
        sby = mby;
        step(1'b1, 1'b1, 1'b1);
        check_int("prio_x", mx, 0);
        check_int("prio_y", my, 0);
        check_int("prio_bx", mbx, sbx + 2);
        check_int("prio_by", mby, sby + ((mdy > 0) ? 2 : -2));
        rd_n(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
